div_unit: RTL and testbench



---
 rtl/div_unit_pkg.sv | 33 +++
 rtl/div_unit.sv | 207 ++++++++++++++++++++
 tb/tb_div_unit.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg -- shared constants and helpers for the iterative divider.
//
// Holds the RV32M funct3 encodings for the four divide instructions, the
// divider FSM state encoding, and small decode helpers. Imported by
// div_unit with `import div_unit_pkg::*`.

package div_unit_pkg;

  localparam int XLEN = 32;

  // RV32M funct3 encodings for the divide group.
  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  // Signed variants treat operands as two's complement.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == FUNCT3_DIV) || (op == FUNCT3_REM);
  endfunction

  // Remainder variants return the remainder instead of the quotient.
  function automatic logic op_is_rem(input logic [2:0] op);
    return (op == FUNCT3_REM) || (op == FUNCT3_REMU);
  endfunction

endpackage

// File: rtl/div_unit.sv
// div_unit -- iterative 32-bit radix-2 restoring divider for RV32M
// DIV/DIVU/REM/REMU, fed from the ID/EX register.
//
// Ports:
//   sys_clk         clock, all state updates on its rising edge
//   sys_rst         synchronous active-high reset
//   start           accept request (sampled only in IDLE)
//   op[2:0]         funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   dividend[31:0]  rs1 value
//   divisor[31:0]   rs2 value
//   rd_addr[4:0]    destination register
//   abort           cancel the operation in flight (flush)
//   busy            high in every state except IDLE
//   hold_req        busy | (start & IDLE), stalls the front end
//   ready           one-cycle completion pulse
//   result[31:0]    quotient or remainder, held until next completion
//   result_rd_addr  rd captured at start, held with result
//   result_wen      same as ready
//
// Optional feature: define DIV_FAST_SPECIAL_EN to send divide-by-zero and
// signed overflow straight from IDLE to FIX (latency 1 instead of 33).

module div_unit
  import div_unit_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  dividend,
  input  logic [XLEN-1:0]  divisor,
  input  logic [4:0]       rd_addr,
  input  logic             abort,
  output logic             busy,
  output logic             hold_req,
  output logic             ready,
  output logic [XLEN-1:0]  result,
  output logic [4:0]       result_rd_addr,
  output logic             result_wen
);

  // Control state (reset).
  div_state_e      state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      res_rd_q, res_rd_d;

  // Operation datapath (loaded at start).
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            dvd_neg_q, dvd_neg_d;
  logic            dvs_neg_q, dvs_neg_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] dvd_raw_q, dvd_raw_d;
  logic [XLEN-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [XLEN-1:0] quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
  logic [XLEN:0]   rem_q, rem_d;     // 33-bit partial remainder

  // Start-time decode.
  logic            in_signed, in_dvd_neg, in_dvs_neg, in_div0, in_ovf;
  logic [XLEN-1:0] in_dvd_mag, in_dvs_mag;

  assign in_signed  = op_is_signed(op);
  assign in_dvd_neg = in_signed & dividend[XLEN-1];
  assign in_dvs_neg = in_signed & divisor[XLEN-1];
  assign in_dvd_mag = in_dvd_neg ? -dividend : dividend;
  assign in_dvs_mag = in_dvs_neg ? -divisor : divisor;
  assign in_div0    = (divisor == '0);
  assign in_ovf     = in_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);

  // One restoring step: shift in the next dividend MSB and trial-subtract.
  // Bit 33 of the difference is the borrow.
  logic [XLEN+1:0] trial;
  assign trial = {rem_q, quo_q[XLEN-1]} - {2'b00, dvs_q};

  // Sign fix-up and special-case substitution applied in FIX.
  logic [XLEN-1:0] fix_quo, fix_rem, fix_result;

  always_comb begin
    fix_quo = (dvd_neg_q ^ dvs_neg_q) ? -quo_q : quo_q;
    fix_rem = dvd_neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    if (div0_q) begin
      fix_quo = '1;
      fix_rem = dvd_raw_q;
    end else if (ovf_q) begin
      fix_quo = 32'h8000_0000;
      fix_rem = '0;
    end
    fix_result = op_is_rem(op_q) ? fix_rem : fix_quo;
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; an unassigned path in always_comb infers a latch.
    state_d   = state_q;
    count_d   = count_q;
    ready_d   = 1'b0;
    result_d  = result_q;
    res_rd_d  = res_rd_q;
    op_d      = op_q;
    rd_d      = rd_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    dvd_raw_d = dvd_raw_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    rem_d     = rem_q;

    unique case (state_q)
      ST_IDLE: begin
        // abort wins over a simultaneous start.
        if (start && !abort) begin
          op_d      = op;
          rd_d      = rd_addr;
          dvd_neg_d = in_dvd_neg;
          dvs_neg_d = in_dvs_neg;
          div0_d    = in_div0;
          ovf_d     = in_ovf;
          dvd_raw_d = dividend;
          dvs_d     = in_dvs_mag;
          quo_d     = in_dvd_mag;
          rem_d     = '0;
          count_d   = '0;
          state_d   = ST_CALC;
`ifdef DIV_FAST_SPECIAL_EN
          if (in_div0 || in_ovf) state_d = ST_FIX;
`endif
        end
      end

      ST_CALC: begin
        if (!trial[XLEN+1]) begin
          rem_d = trial[XLEN:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) state_d = ST_FIX;
      end

      ST_FIX: begin
        ready_d  = 1'b1;
        result_d = fix_result;
        res_rd_d = rd_q;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A flush drops the operation without a completion and leaves the
    // previous result visible.
    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
      res_rd_d = res_rd_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      ready_q  <= 1'b0;
      result_q <= '0;
      res_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      result_q <= result_d;
      res_rd_q <= res_rd_d;
    end
  end

  // NOTE: operand and iteration registers are always loaded at start before
  // being read, so they carry no reset.
  always_ff @(posedge sys_clk) begin
    op_q      <= op_d;
    rd_q      <= rd_d;
    dvd_neg_q <= dvd_neg_d;
    dvs_neg_q <= dvs_neg_d;
    div0_q    <= div0_d;
    ovf_q     <= ovf_d;
    dvd_raw_q <= dvd_raw_d;
    dvs_q     <= dvs_d;
    quo_q     <= quo_d;
    rem_q     <= rem_d;
  end

  assign busy           = (state_q != ST_IDLE);
  assign hold_req       = busy | (start & (state_q == ST_IDLE));
  assign ready          = ready_q;
  assign result_wen     = ready_q;
  assign result         = result_q;
  assign result_rd_addr = res_rd_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- self-checking bench for div_unit.
//
// A reference model computes each result from RV32M arithmetic rules and the
// expected completion latency; a compare loop checks every DUT output on the
// falling edge of every cycle. Directed vectors also check literal results.
// Honours DIV_FAST_SPECIAL_EN the same way as the design.

module tb_div_unit;
  import div_unit_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [4:0]  rd_addr = '0;
  logic        abort = 1'b0;
  logic        busy, hold_req, ready, result_wen;
  logic [31:0] result;
  logic [4:0]  result_rd_addr;

  div_unit dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .start          (start),
    .op             (op),
    .dividend       (dividend),
    .divisor        (divisor),
    .rd_addr        (rd_addr),
    .abort          (abort),
    .busy           (busy),
    .hold_req       (hold_req),
    .ready          (ready),
    .result         (result),
    .result_rd_addr (result_rd_addr),
    .result_wen     (result_wen)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Events posted by the driver at clock edges, consumed by the compare loop.
  int          issue_seq = 0, abort_seq = 0, rst_seq = 0;
  int          iss_lat;
  logic [31:0] iss_res;
  logic [4:0]  iss_rd;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // RV32M reference semantics.
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    bit is_signed = (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    bit is_rem    = (f3 == FUNCT3_REM) || (f3 == FUNCT3_REMU);
    int sa, sb;
    if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
    if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return is_rem ? 32'h0 : 32'h8000_0000;
    if (is_signed) begin
      sa = $signed(a);
      sb = $signed(b);
      return is_rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return is_rem ? a % b : a / b;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef DIV_FAST_SPECIAL_EN
    bit is_signed = (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    if (b == 0 || (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
    return 33;
  endfunction

  // Checks every output against the model once per cycle.
  task automatic compare_loop();
    int seen_issue = 0, seen_abort = 0, seen_rst = 0;
    bit pend = 1'b0;
    int remaining = 0;
    logic [31:0] exp_res = '0, last_res = '0;
    logic [4:0]  exp_rd = '0, last_rd = '0;
    logic exp_busy, exp_ready;
    forever begin
      @(negedge sys_clk);
      if (rst_seq != seen_rst) begin
        seen_rst = rst_seq;
        pend = 1'b0;
        last_res = '0;
        last_rd = '0;
      end
      if (abort_seq != seen_abort) begin
        seen_abort = abort_seq;
        pend = 1'b0;
      end
      if (issue_seq != seen_issue) begin
        seen_issue = issue_seq;
        pend = 1'b1;
        remaining = iss_lat;
        exp_res = iss_res;
        exp_rd = iss_rd;
      end
      exp_busy  = pend && (remaining > 0);
      exp_ready = pend && (remaining == 0);
      if (exp_ready) begin
        last_res = exp_res;
        last_rd = exp_rd;
      end
      if (chk_en) begin
        check("busy", 32'(busy), 32'(exp_busy));
        check("ready", 32'(ready), 32'(exp_ready));
        check("result_wen", 32'(result_wen), 32'(exp_ready));
        check("hold_req", 32'(hold_req), 32'(exp_busy | start));
        check("result", result, last_res);
        check("result_rd_addr", 32'(result_rd_addr), 32'(last_rd));
      end
      if (pend) begin
        if (remaining == 0) pend = 1'b0;
        else remaining--;
      end
    end
  endtask

  // Called just after a rising edge; returns just after the start edge E0.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat);
    start = 1'b1;
    op = f3;
    dividend = a;
    divisor = b;
    rd_addr = rd;
    lat = ref_lat(f3, a, b);
    iss_lat = lat;
    iss_res = ref_div(f3, a, b);
    iss_rd = rd;
    @(posedge sys_clk);
    issue_seq++;
    #1;
    start = 1'b0;
    op = 3'($urandom);
    dividend = $urandom;
    divisor = $urandom;
    rd_addr = 5'($urandom);
  endtask

  // Runs one operation to completion and checks the literal result in the
  // ready cycle.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] lit);
    int lat;
    issue(f3, a, b, rd, lat);
    repeat (lat) @(posedge sys_clk);
    #1;
    check({name, "_ready"}, 32'(ready), 32'd1);
    check(name, result, lit);
    check({name, "_rd"}, 32'(result_rd_addr), 32'(rd));
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 50));
      default: return $urandom;
    endcase
  endfunction

  task automatic driver();
    int lat;
    logic [2:0] f3;
    logic [31:0] a, b;

    // Pin the reference model with hand-computed values.
    check("pin_divu", ref_div(FUNCT3_DIVU, 100, 7), 32'd14);
    check("pin_remu", ref_div(FUNCT3_REMU, 100, 7), 32'd2);
    check("pin_rem_neg", ref_div(FUNCT3_REM, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFF);
    check("pin_div_neg", ref_div(FUNCT3_DIV, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFD);
    check("pin_div_ovf", ref_div(FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("pin_rem_div0", ref_div(FUNCT3_REM, 32'hFFFF_FFFB, 0), 32'hFFFF_FFFB);

    sys_rst = 1'b1;
    repeat (3) begin
      @(posedge sys_clk);
      rst_seq++;
    end
    #1;
    sys_rst = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", 32'(result_rd_addr), 32'd0);
    @(posedge sys_clk);
    #1;

    // Directed vectors; several run back to back (start in the ready cycle).
    run_op("divu_100_7", FUNCT3_DIVU, 100, 7, 5'd1, 32'd14);
    run_op("remu_100_7", FUNCT3_REMU, 100, 7, 5'd2, 32'd2);
    run_op("rem_m7_2", FUNCT3_REM, 32'hFFFF_FFF9, 2, 5'd3, 32'hFFFF_FFFF);
    run_op("div_m7_2", FUNCT3_DIV, 32'hFFFF_FFF9, 2, 5'd4, 32'hFFFF_FFFD);
    run_op("div_ovf", FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'h8000_0000);
    run_op("rem_ovf", FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h0);
    run_op("divu_5_0", FUNCT3_DIVU, 5, 0, 5'd7, 32'hFFFF_FFFF);
    run_op("remu_5_0", FUNCT3_REMU, 5, 0, 5'd8, 32'd5);
    run_op("div_m5_0", FUNCT3_DIV, 32'hFFFF_FFFB, 0, 5'd9, 32'hFFFF_FFFF);
    run_op("rem_m5_0", FUNCT3_REM, 32'hFFFF_FFFB, 0, 5'd10, 32'hFFFF_FFFB);
    run_op("divu_max", FUNCT3_DIVU, 32'hFFFF_FFFF, 1, 5'd11, 32'hFFFF_FFFF);

    // Abort and start together in IDLE: start must be ignored.
    start = 1'b1;
    abort = 1'b1;
    op = FUNCT3_DIVU;
    dividend = 9;
    divisor = 3;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(posedge sys_clk);
    #1;

    // Abort 10 cycles after start, then a fresh start in the next cycle.
    issue(FUNCT3_DIVU, 1000, 3, 5'd12, lat);
    repeat (9) @(posedge sys_clk);
    #1;
    abort = 1'b1;
    @(posedge sys_clk);
    abort_seq++;
    #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    run_op("after_abort", FUNCT3_REMU, 1000, 3, 5'd13, 32'd1);

    // Reset at cycle 20 of an operation with start held during reset.
    issue(FUNCT3_DIV, 32'hFFFF_FF00, 7, 5'd14, lat);
    repeat (19) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    start = 1'b1;
    op = FUNCT3_DIVU;
    dividend = 77;
    divisor = 7;
    rd_addr = 5'd15;
    @(posedge sys_clk);
    rst_seq++;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_rd", 32'(result_rd_addr), 32'd0);
    @(posedge sys_clk);
    rst_seq++;
    #1;
    sys_rst = 1'b0;
    start = 1'b0;
    repeat (40) @(posedge sys_clk);
    #1;

    // Randomized operations with occasional idle gaps.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: f3 = FUNCT3_DIV;
        1: f3 = FUNCT3_DIVU;
        2: f3 = FUNCT3_REM;
        default: f3 = FUNCT3_REMU;
      endcase
      a = rand_operand();
      b = rand_operand();
      issue(f3, a, b, 5'($urandom), lat);
      repeat (lat) @(posedge sys_clk);
      #1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge sys_clk);
        #1;
      end
    end
    repeat (3) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    fork
      driver();
      compare_loop();
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
